// File: rtl/pixel_pkg.sv
// Shared definitions for the byte-stream to pixel unpacker.
package pixel_pkg;

  typedef enum logic [1:0] {
    MODE_RGB888   = 2'd0,
    MODE_RGBA8888 = 2'd1,
    MODE_RGB565   = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [2:0] bytes_per_pixel(input mode_t m);
    case (m)
      MODE_RGBA8888: return 3'd4;
      MODE_RGB565:   return 3'd2;
      default:       return 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/rgb565_expand.sv
// RGB565 to RGB888 expansion; low bits replicate the top bits of each field.
module rgb565_expand (
  input  logic [15:0] i_pix,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b
);

  assign o_r = {i_pix[15:11], i_pix[15:13]};
  assign o_g = {i_pix[10:5],  i_pix[10:9]};
  assign o_b = {i_pix[4:0],   i_pix[4:2]};

endmodule

// File: rtl/pixel_unpack.sv
// Assembles a byte stream into RGB pixels and writes them to video memory
// through a single pending slot, counting pixels up to a per-frame target.
module pixel_unpack
  import pixel_pkg::*;
#(
  parameter int PIX_W = 24
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             frame_start,
  input  logic [1:0]       cfg_mode,
  input  logic [15:0]      H,
  input  logic [15:0]      V,
  input  logic [7:0]       interlaced,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             vram_ready,
  output logic             vram_req,
  output logic [7:0]       r_vram_out,
  output logic [7:0]       g_vram_out,
  output logic [7:0]       b_vram_out,
  output logic [PIX_W-1:0] pixel_count,
  output logic             frame_done,
  output logic             frame_abort,
  output logic             busy
);

  localparam logic [PIX_W-1:0] ONE = PIX_W'(1);

  state_t           r_state, w_state_next;
  mode_t            r_mode, w_mode_new;
  logic [PIX_W-1:0] r_target, w_target_new;
  logic [PIX_W-1:0] r_asm_count, r_pix_count;
  logic [1:0]       r_byte_idx;
  logic [7:0]       r_byte0, r_byte1, r_byte2;
  logic             r_pend_valid, r_frame_done, r_frame_abort;
  logic [7:0]       r_r, r_g, r_b;

  logic [31:0]      w_area;
  logic [2:0]       w_bpp;
  logic             w_last_byte, w_accept, w_complete, w_vram_req, w_last_pix;
  logic [7:0]       w_r565, w_g565, w_b565;
  logic [7:0]       w_pix_r, w_pix_g, w_pix_b;

  assign w_area       = 32'(H) * 32'(V);
  assign w_target_new = PIX_W'((interlaced != 8'd0) ? (w_area >> 1) : w_area);
  assign w_mode_new   = (cfg_mode == MODE_RSVD) ? MODE_RGB888 : mode_t'(cfg_mode);

  assign w_bpp       = bytes_per_pixel(r_mode);
  assign w_last_byte = ({1'b0, r_byte_idx} == (w_bpp - 3'd1));
  assign w_vram_req  = r_pend_valid && vram_ready;
  assign w_last_pix  = w_vram_req && (r_pix_count == (r_target - ONE));

  // A byte seen together with frame_start would be discarded by the restart,
  // so it is not acknowledged.
  assign in_ready = (r_state == RUN) && !frame_start &&
                    (r_asm_count < r_target) &&
                    !(w_last_byte && r_pend_valid && !vram_ready);

  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && w_last_byte;

  rgb565_expand u_rgb565 (
    .i_pix ({in_data, r_byte0}),
    .o_r   (w_r565),
    .o_g   (w_g565),
    .o_b   (w_b565)
  );

  always_comb begin
    w_pix_r = r_byte0;
    w_pix_g = r_byte1;
    w_pix_b = in_data;
    case (r_mode)
      MODE_RGBA8888: w_pix_b = r_byte2;
      MODE_RGB565: begin
        w_pix_r = w_r565;
        w_pix_g = w_g565;
        w_pix_b = w_b565;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (frame_start)
      w_state_next = (w_target_new == '0) ? IDLE : RUN;
    else if ((r_state == RUN) && w_last_pix)
      w_state_next = IDLE;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_mode        <= MODE_RGB888;
      r_target      <= '0;
      r_asm_count   <= '0;
      r_pix_count   <= '0;
      r_byte_idx    <= '0;
      r_byte0       <= '0;
      r_byte1       <= '0;
      r_byte2       <= '0;
      r_pend_valid  <= 1'b0;
      r_r           <= '0;
      r_g           <= '0;
      r_b           <= '0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_frame_done  <= frame_start ? (w_target_new == '0) : w_last_pix;
      r_frame_abort <= frame_start && (r_state == RUN);
      if (frame_start) begin
        r_mode       <= w_mode_new;
        r_target     <= w_target_new;
        r_asm_count  <= '0;
        r_pix_count  <= '0;
        r_byte_idx   <= '0;
        r_pend_valid <= 1'b0;
      end else begin
        if (w_accept) begin
          if (w_last_byte) begin
            r_byte_idx  <= '0;
            r_asm_count <= r_asm_count + ONE;
            r_r         <= w_pix_r;
            r_g         <= w_pix_g;
            r_b         <= w_pix_b;
          end else begin
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0:    r_byte0 <= in_data;
              2'd1:    r_byte1 <= in_data;
              default: r_byte2 <= in_data;
            endcase
          end
        end
        // A pixel completing on the drain edge reloads the slot.
        if (w_complete)      r_pend_valid <= 1'b1;
        else if (w_vram_req) r_pend_valid <= 1'b0;
        if (w_vram_req) r_pix_count <= r_pix_count + ONE;
      end
    end
  end

  assign vram_req    = w_vram_req;
  assign r_vram_out  = r_r;
  assign g_vram_out  = r_g;
  assign b_vram_out  = r_b;
  assign pixel_count = r_pix_count;
  assign frame_done  = r_frame_done;
  assign frame_abort = r_frame_abort;
  assign busy        = (r_state == RUN);

endmodule

// File: tb/tb_pixel_unpack.sv
// Self-checking bench for pixel_unpack: queue-based frame model plus directed cases.
module tb_pixel_unpack;

  localparam int PIX_W = 24;

  logic             clk_sys = 1'b0;
  logic             reset_n = 1'b0;
  logic             frame_start = 1'b0;
  logic [1:0]       cfg_mode = '0;
  logic [15:0]      H = '0;
  logic [15:0]      V = '0;
  logic [7:0]       interlaced = '0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = '0;
  logic             vram_ready = 1'b0;
  logic             in_ready, vram_req, frame_done, frame_abort, busy;
  logic [7:0]       r_vram_out, g_vram_out, b_vram_out;
  logic [PIX_W-1:0] pixel_count;

  always #5 clk_sys = ~clk_sys;

  pixel_unpack #(.PIX_W(PIX_W)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .cfg_mode    (cfg_mode),
    .H           (H),
    .V           (V),
    .interlaced  (interlaced),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .vram_ready  (vram_ready),
    .vram_req    (vram_req),
    .r_vram_out  (r_vram_out),
    .g_vram_out  (g_vram_out),
    .b_vram_out  (b_vram_out),
    .pixel_count (pixel_count),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .busy        (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Frame model: bytes collected per pixel, at most one pixel awaiting vram.
  bit              m_run = 0, m_done = 0, m_abort = 0;
  int              m_mode = 0, m_bpp = 3, m_nasm = 0, m_npix = 0;
  longint unsigned m_target = 0;
  logic [7:0]      m_part[$];
  logic [23:0]     m_pend[$];

  logic [23:0]     wlog[$];
  logic [7:0]      src[$];
  int              done_cnt = 0, abort_cnt = 0, done_pc = 0;

  function automatic logic [23:0] model_pix(input int mode, input logic [7:0] b0, b1, b2);
    int p;
    if (mode == 2) begin
      p = int'(b1) * 256 + int'(b0);
      return {8'((p / 2048) * 8 + p / 8192),
              8'(((p / 32) % 64) * 4 + (p / 512) % 4),
              8'((p % 32) * 8 + (p % 32) / 4)};
    end
    return {b0, b1, b2};
  endfunction

  initial begin
    bit exp_vreq, exp_rdy;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        chk("rst_in_ready", in_ready, 0);
        chk("rst_vram_req", vram_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_abort", frame_abort, 0);
        chk("rst_pixel_count", pixel_count, 0);
        chk("rst_rgb", {r_vram_out, g_vram_out, b_vram_out}, 0);
        m_run = 0; m_done = 0; m_abort = 0; m_nasm = 0; m_npix = 0;
        m_target = 0; m_bpp = 3; m_mode = 0;
        m_part.delete(); m_pend.delete();
      end else begin
        exp_vreq = (m_pend.size() != 0) && vram_ready;
        exp_rdy  = m_run && (m_nasm < m_target) &&
                   !((m_part.size() == m_bpp - 1) && (m_pend.size() != 0) && !vram_ready);
        if (!frame_start) chk("in_ready", in_ready, exp_rdy);
        chk("vram_req", vram_req, exp_vreq);
        chk("busy", busy, m_run);
        chk("pixel_count", pixel_count, m_npix);
        chk("frame_done", frame_done, m_done);
        chk("frame_abort", frame_abort, m_abort);
        if (m_pend.size() != 0)
          chk("pixel_data", {r_vram_out, g_vram_out, b_vram_out}, m_pend[0]);
        if (vram_req) wlog.push_back({r_vram_out, g_vram_out, b_vram_out});
        if (frame_done) begin done_cnt++; done_pc = int'(pixel_count); end
        if (frame_abort) abort_cnt++;

        m_done = 0; m_abort = 0;
        if (frame_start) begin
          m_target = ((longint'(H) * longint'(V)) >> ((interlaced != 0) ? 1 : 0)) & 64'hFF_FFFF;
          m_abort  = m_run;
          m_mode   = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
          m_bpp    = (m_mode == 1) ? 4 : (m_mode == 2) ? 2 : 3;
          m_part.delete(); m_pend.delete();
          m_nasm = 0; m_npix = 0;
          m_run  = (m_target != 0);
          m_done = (m_target == 0);
        end else if (m_run) begin
          if (exp_vreq) begin
            void'(m_pend.pop_front());
            m_npix++;
            if (m_npix == m_target) begin m_run = 0; m_done = 1; end
          end
          if (in_valid && exp_rdy) begin
            m_part.push_back(in_data);
            if (m_part.size() == m_bpp) begin
              m_pend.push_back(model_pix(m_mode, m_part[0], m_part[1],
                                         (m_bpp == 2) ? 8'h00 : m_part[2]));
              m_nasm++;
              m_part.delete();
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_frame(input logic [1:0] mode, input logic [15:0] h, v, input logic [7:0] il);
    cfg_mode = mode; H = h; V = v; interlaced = il;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    // Later changes of the configuration inputs must not affect the frame.
    cfg_mode = 2'($urandom); H = 16'($urandom); V = 16'($urandom); interlaced = 8'($urandom);
  endtask

  task automatic feed(input int base, input bit wait_done, input int pv, input int pr,
                      input int stall_at, output int nacc);
    int cyc;
    nacc = 0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      if (wait_done ? (done_cnt > base) : (nacc >= src.size())) break;
      in_valid   = (nacc < src.size()) && ($urandom_range(99) < pv);
      in_data    = (nacc < src.size()) ? src[nacc] : 8'h00;
      vram_ready = (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 10) ? 1'b0
                   : ($urandom_range(99) < pr);
      @(negedge clk_sys);
      if (in_valid && in_ready) nacc++;
      tick();
    end
    in_valid = 1'b0;
    chk("feed_timeout", (cyc < 2000), 1);
  endtask

  task automatic fill_src(input logic [7:0] first, input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(8'(int'(first) + i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nacc, abase;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("post_reset_busy", busy, 0);
    chk("post_reset_in_ready", in_ready, 0);
    chk("post_reset_pixel_count", pixel_count, 0);

    // RGB888 4x2, full throughput
    base = done_cnt; wlog.delete(); fill_src(8'h01, 24);
    start_frame(2'd0, 16'd4, 16'd2, 8'd0);
    feed(base, 1, 100, 100, -1, nacc);
    chk("t1_bytes", nacc, 24);
    chk("t1_npix", wlog.size(), 8);
    chk("t1_first", wlog[0], 24'h010203);
    chk("t1_last", wlog[7], 24'h161718);
    chk("t1_done_count", done_pc, 8);

    // RGB565 expansion
    base = done_cnt; wlog.delete();
    src = '{8'h1F, 8'hF8, 8'hE0, 8'h07};
    start_frame(2'd2, 16'd2, 16'd1, 8'd0);
    feed(base, 1, 100, 100, -1, nacc);
    chk("t2_magenta", wlog[0], 24'hFF00FF);
    chk("t2_green", wlog[1], 24'h00FF00);

    // RGBA8888 field frame, surplus bytes back-pressured
    base = done_cnt; wlog.delete(); fill_src(8'h10, 12);
    start_frame(2'd1, 16'd2, 16'd2, 8'd1);
    feed(base, 1, 100, 100, -1, nacc);
    chk("t3_bytes", nacc, 8);
    chk("t3_pix0", wlog[0], 24'h101112);
    chk("t3_pix1", wlog[1], 24'h141516);
    in_valid = 1'b1; in_data = 8'h55;
    repeat (4) begin
      tick();
      chk("t3_surplus_ready", in_ready, 0);
    end
    in_valid = 1'b0;

    // vram_ready low for 10 cycles mid-frame
    base = done_cnt; wlog.delete(); fill_src(8'h01, 24);
    start_frame(2'd0, 16'd4, 16'd2, 8'd0);
    feed(base, 1, 100, 100, 7, nacc);
    chk("t4_npix", wlog.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("t4_seq", wlog[i], {8'(3*i+1), 8'(3*i+2), 8'(3*i+3)});

    // restart after 5 bytes
    fill_src(8'h01, 5);
    start_frame(2'd0, 16'd4, 16'd2, 8'd0);
    feed(done_cnt, 0, 100, 100, -1, nacc);
    abase = abort_cnt; base = done_cnt; wlog.delete();
    start_frame(2'd0, 16'd4, 16'd2, 8'd0);
    chk("t5_count_cleared", pixel_count, 0);
    tick();
    chk("t5_abort_pulse", abort_cnt, abase + 1);
    fill_src(8'h41, 24);
    feed(base, 1, 100, 100, -1, nacc);
    chk("t5_fresh_pixel", wlog[0], 24'h414243);
    chk("t5_done_count", done_pc, 8);

    // reset mid-frame with a pixel pending
    fill_src(8'h01, 5);
    start_frame(2'd0, 16'd4, 16'd2, 8'd0);
    feed(done_cnt, 0, 100, 0, -1, nacc);
    base = done_cnt;
    reset_n = 1'b0; vram_ready = 1'b1;
    #1;
    chk("t6_async_in_ready", in_ready, 0);
    chk("t6_async_vram_req", vram_req, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_count", pixel_count, 0);
    chk("t6_async_rgb", {r_vram_out, g_vram_out, b_vram_out}, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    chk("t6_no_done", done_cnt, base);

    // randomized frames
    for (int f = 0; f < 25; f++) begin
      base = done_cnt; wlog.delete();
      src.delete();
      for (int i = 0; i < 100; i++) src.push_back(8'($urandom));
      start_frame(2'($urandom), 16'($urandom_range(0, 5)), 16'($urandom_range(1, 4)),
                  ($urandom_range(1) != 0) ? 8'($urandom_range(1, 255)) : 8'd0);
      feed(base, 1, int'($urandom_range(30, 100)), int'($urandom_range(20, 100)), -1, nacc);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
